// File: rtl/control_transaccion.sv
// Transaction-layer control FSM: sequences fabric reset, threshold load, arbiter enable,
// idle reporting and sticky FIFO error capture. Optional macro: CTRL_THRESHOLD_CHECK_EN.
module control_transaccion #(
    parameter int N_FIFOS = 8,
    parameter int AW      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [AW-1:0]      umbral_af_in,
    input  logic [AW-1:0]      umbral_ae_in,
    input  logic [N_FIFOS-1:0] fifo_empty,
    input  logic [N_FIFOS-1:0] fifo_error,
    output logic [2:0]         estado,
    output logic [AW-1:0]      umbral_af,
    output logic [AW-1:0]      umbral_ae,
    output logic               enable,
    output logic               idle,
    output logic [N_FIFOS-1:0] error_out
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [AW-1:0]      r_af;
    logic [AW-1:0]      r_ae;
    logic               r_enable;
    logic               r_idle;
    logic [N_FIFOS-1:0] r_err;
    logic               w_cfg_ok;
    logic               w_all_empty;
    logic               w_any_err;

`ifdef CTRL_THRESHOLD_CHECK_EN
    // A zero almost-full level or an almost-empty level at/above it would make the flags meaningless.
    assign w_cfg_ok = (umbral_af_in != '0) && (umbral_ae_in < umbral_af_in);
`else
    assign w_cfg_ok = 1'b1;
`endif

    assign w_all_empty = &fifo_empty;
    assign w_any_err   = |fifo_error;

    always_comb begin
        w_next = S_RESET;
        case (r_state)
            S_RESET:  w_next = S_INIT;
            S_INIT:   w_next = (!init && w_cfg_ok) ? S_IDLE : S_INIT;
            S_IDLE: begin
                if (w_any_err)         w_next = S_ERROR;
                else if (init)         w_next = S_INIT;
                else if (!w_all_empty) w_next = S_ACTIVE;
                else                   w_next = S_IDLE;
            end
            S_ACTIVE: begin
                if (w_any_err)         w_next = S_ERROR;
                else if (init)         w_next = S_INIT;
                else if (w_all_empty)  w_next = S_IDLE;
                else                   w_next = S_ACTIVE;
            end
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_RESET;
        endcase
    end

    // Outputs are derived from the next state so they line up with the registered state code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_RESET;
            r_af     <= '0;
            r_ae     <= '0;
            r_enable <= 1'b0;
            r_idle   <= 1'b0;
            r_err    <= '0;
        end else begin
            r_state  <= w_next;
            r_enable <= (w_next == S_IDLE) || (w_next == S_ACTIVE);
            r_idle   <= (w_next == S_IDLE);
            if (r_state == S_INIT) begin
                r_af <= umbral_af_in;
                r_ae <= umbral_ae_in;
            end
            if ((r_state == S_IDLE) || (r_state == S_ACTIVE) || (r_state == S_ERROR))
                r_err <= r_err | fifo_error;
        end
    end

    assign estado    = r_state;
    assign umbral_af = r_af;
    assign umbral_ae = r_ae;
    assign enable    = r_enable;
    assign idle      = r_idle;
    assign error_out = r_err;

endmodule

// File: tb/tb_control_transaccion.sv
// Bench for control_transaccion: directed literal checks plus a randomized run compared
// cycle by cycle against a behavioural model of the state rules.
module tb_control_transaccion;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          init = 1'b1;
    logic [AW-1:0] af_in = '0;
    logic [AW-1:0] ae_in = '0;
    logic [N-1:0]  fifo_empty = '1;
    logic [N-1:0]  fifo_error = '0;
    logic [2:0]    estado;
    logic [AW-1:0] umbral_af;
    logic [AW-1:0] umbral_ae;
    logic          enable;
    logic          idle;
    logic [N-1:0]  error_out;

    int n_tests = 0;
    int n_fail  = 0;

    control_transaccion #(.N_FIFOS(N), .AW(AW)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_af_in(af_in), .umbral_ae_in(ae_in),
        .fifo_empty(fifo_empty), .fifo_error(fifo_error),
        .estado(estado), .umbral_af(umbral_af), .umbral_ae(umbral_ae),
        .enable(enable), .idle(idle), .error_out(error_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: state number plus the values the outputs must hold.
    int            m_state = 0;
    logic [AW-1:0] m_af = '0;
    logic [AW-1:0] m_ae = '0;
    logic [N-1:0]  m_err = '0;

    function automatic bit cfg_valid(input logic [AW-1:0] af, input logic [AW-1:0] ae);
`ifdef CTRL_THRESHOLD_CHECK_EN
        return (af != 0) && (ae < af);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int rule_next(input int s, input logic in_init, input logic [N-1:0] emp,
                                     input logic [N-1:0] err, input logic [AW-1:0] af,
                                     input logic [AW-1:0] ae);
        bool_chk: begin end
        if (s == 0) return 1;
        if (s == 1) return (!in_init && cfg_valid(af, ae)) ? 2 : 1;
        if (s == 4) return 4;
        if (s == 2 || s == 3) begin
            if (err != 0)  return 4;
            if (in_init)   return 1;
            if (emp == '1) return 2;
            return 3;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 0;
            m_af    <= '0;
            m_ae    <= '0;
            m_err   <= '0;
        end else begin
            m_state <= rule_next(m_state, init, fifo_empty, fifo_error, af_in, ae_in);
            if (m_state == 1) begin
                m_af <= af_in;
                m_ae <= ae_in;
            end
            if (m_state >= 2) m_err <= m_err | fifo_error;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Compare every cycle, shortly after the active edge.
    always @(posedge clk) begin
        #2;
        check("m_estado", 32'(estado), 32'(m_state));
        check("m_enable", 32'(enable), 32'((m_state == 2) || (m_state == 3)));
        check("m_idle", 32'(idle), 32'(m_state == 2));
        check("m_af", 32'(umbral_af), 32'(m_af));
        check("m_ae", 32'(umbral_ae), 32'(m_ae));
        check("m_err", 32'(error_out), 32'(m_err));
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic check_cleared(input string nm);
        check({nm, "_estado"}, 32'(estado), 32'd0);
        check({nm, "_enable"}, 32'(enable), 32'd0);
        check({nm, "_idle"}, 32'(idle), 32'd0);
        check({nm, "_af"}, 32'(umbral_af), 32'd0);
        check({nm, "_err"}, 32'(error_out), 32'd0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #6 check_cleared("rst0");

        // Bring-up with thresholds 6/2 and init held for three edges.
        step();
        init = 1'b1; af_in = 3'd6; ae_in = 3'd2; reset = 1'b0;
        step(); check("bring_e1", 32'(estado), 32'd1);
        step(); check("bring_e2", 32'(estado), 32'd1);
        step(); check("bring_e3", 32'(estado), 32'd1);
        init = 1'b0;
        step();
        check("bring_e4", 32'(estado), 32'd2);
        check("bring_af", 32'(umbral_af), 32'd6);
        check("bring_ae", 32'(umbral_ae), 32'd2);
        check("bring_en", 32'(enable), 32'd1);
        check("bring_idle", 32'(idle), 32'd1);

        // Traffic arrives and drains.
        fifo_empty = 8'hFE;
        step(); check("act_estado", 32'(estado), 32'd3); check("act_idle", 32'(idle), 32'd0);
        fifo_empty = 8'hFF;
        step(); check("drain_estado", 32'(estado), 32'd2); check("drain_idle", 32'(idle), 32'd1);

        // Error pulse while active, then init is ignored.
        fifo_empty = 8'hFE;
        step();
        fifo_error = 8'h20;
        step();
        fifo_error = 8'h00;
        check("err_estado", 32'(estado), 32'd4);
        check("err_en", 32'(enable), 32'd0);
        check("err_out", 32'(error_out), 32'h20);
        init = 1'b1; step(); init = 1'b0; step();
        check("err_sticky", 32'(estado), 32'd4);
        check("err_thr", 32'(umbral_af), 32'd6);
        reset = 1'b1;
        #1 check_cleared("rst_err");
        step();

        // Simultaneous init and error in IDLE.
        fifo_empty = 8'hFF; init = 1'b0; reset = 1'b0;
        step(); check("r2_e1", 32'(estado), 32'd1);
        step(); check("r2_e2", 32'(estado), 32'd2);
        init = 1'b1; fifo_error = 8'h01;
        step();
        init = 1'b0; fifo_error = 8'h00;
        check("both_estado", 32'(estado), 32'd4);
        check("both_err", 32'(error_out), 32'h01);

        // Asynchronous reset in the middle of ACTIVE.
        reset = 1'b1; step(); reset = 1'b0;
        step(); step();
        fifo_empty = 8'h7F;
        step(); check("mid_active", 32'(estado), 32'd3);
        #2 reset = 1'b1;
        #1 check_cleared("rst_mid");
        step();

        // Threshold validation: af=2, ae=3 is invalid when checking is enabled.
        fifo_empty = 8'hFF; init = 1'b1; af_in = 3'd2; ae_in = 3'd3; reset = 1'b0;
        step(); check("thr_e1", 32'(estado), 32'd1);
        init = 1'b0;
        step();
`ifdef CTRL_THRESHOLD_CHECK_EN
        check("thr_hold", 32'(estado), 32'd1);
        ae_in = 3'd1;
        step();
        check("thr_exit", 32'(estado), 32'd2);
        check("thr_ae", 32'(umbral_ae), 32'd1);
`else
        check("thr_exit", 32'(estado), 32'd2);
        check("thr_ae", 32'(umbral_ae), 32'd3);
`endif

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            init       = ($urandom_range(0, 9) == 0);
            af_in      = AW'($urandom);
            ae_in      = AW'($urandom);
            fifo_empty = ($urandom_range(0, 1) == 0) ? 8'hFF : N'($urandom);
            fifo_error = ($urandom_range(0, 39) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            if ($urandom_range(0, 59) == 0) begin
                #($urandom_range(0, 4)) reset = 1'b1;
                #1 check_cleared("rnd_rst");
            end else begin
                reset = 1'b0;
            end
            step();
        end
        reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_transaccion.md
# control_transaccion

Top-level control state machine for the transaction layer. It sequences the four input FIFOs, the four output FIFOs and the 4x4 weighted arbiter: it holds the fabric in reset, loads the almost-full and almost-empty thresholds, and gates the arbiter `Enable`. It also reports idle status and latches FIFO overflow/underflow errors.

## Interface
Parameters:
- `N_FIFOS`, 8: number of monitored FIFOs (bits [3:0] input FIFOs, [7:4] output FIFOs).
- `AW`, 3: threshold width (FIFO depth 2^AW).

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `init`  in  1  request (re)configuration.
- `umbral_af_in`  in  AW  almost-full threshold to load.
- `umbral_ae_in`  in  AW  almost-empty threshold to load.
- `fifo_empty`  in  N_FIFOS  per-FIFO empty flags.
- `fifo_error`  in  N_FIFOS  per-FIFO overflow/underflow pulse.
- `estado`  out  3  current state code.
- `umbral_af`  out  AW  registered almost-full threshold to all FIFOs.
- `umbral_ae`  out  AW  registered almost-empty threshold to all FIFOs.
- `enable`  out  1  arbiter/FIFO enable.
- `idle`  out  1  all FIFOs empty and fabric enabled.
- `error_out`  out  N_FIFOS  sticky per-FIFO error record.

## Operation
- States and codes: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. Codes 5–7 are illegal; if reached, the next state is RESET.
- `reset` high, asynchronously: state RESET; `umbral_af`, `umbral_ae`, `enable`, `idle`, `error_out` all 0.
- RESET: on the first edge with `reset` low, go to INIT unconditionally.
- INIT: each cycle, load `umbral_af`<=`umbral_af_in` and `umbral_ae`<=`umbral_ae_in`. `enable`=0. When `init`=0, go to IDLE; the values loaded on that final cycle are kept.
- IDLE: `enable`=1. Exits, in priority order:
  - any `fifo_error` bit set: go to ERROR;
  - `init`=1: go to INIT;
  - `fifo_empty` != all-ones: go to ACTIVE;
  - otherwise stay in IDLE.
- ACTIVE: `enable`=1. Exits, in priority order:
  - error: go to ERROR;
  - `init`=1: go to INIT;
  - `fifo_empty` all-ones: go to IDLE;
  - otherwise stay in ACTIVE.
- ERROR: `enable`=0. Stays in ERROR until `reset`; `init` is ignored.
- `error_out`: on every edge in IDLE or ACTIVE, `error_out`<=`error_out` | `fifo_error`. In ERROR the OR also accumulates. Errors in RESET/INIT are ignored. Cleared only by `reset`.
- `idle`=1 exactly when the registered state is IDLE and `fifo_empty` was all-ones on the transition edge. In practice `idle` equals (state==IDLE).
- Thresholds are frozen outside INIT; they are never altered by ERROR.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Condition sampled at edge k gives the new state and outputs after edge k (1-cycle latency).
- Reset release: RESET, then INIT one edge later, then IDLE one edge after `init` is seen low. The minimum is 2 edges from release to `enable`=1.
- Simultaneous `init` and `fifo_error` in IDLE/ACTIVE: ERROR wins, and the error bit is recorded.
- `init` re-asserted mid-traffic: `enable` drops after the next edge. The arbiter stops popping; FIFO contents are preserved.
- `reset` mid-operation: immediate asynchronous clear, regardless of state.
- Single-cycle `fifo_error` pulses must be captured; no multi-cycle width is required.

## Configuration
- `CTRL_THRESHOLD_CHECK_EN` defined:
  - INIT additionally validates the loaded values. A value is invalid if `umbral_af_in`==0 or `umbral_ae_in` >= `umbral_af_in`.
  - With invalid values, INIT does not exit even when `init`=0, and internal `cfg_invalid` forces `error_out` unchanged but `estado` stays 1.
  - Exit occurs on the first edge with `init`=0 and valid values.
- Not defined: no validation; exit on `init`=0 with any values.

## Test plan
- Reset release with `init`=1 for 3 cycles, af_in=6, ae_in=2, then `init`=0 -> `estado` 0,1,1,1,2; `umbral_af`=6, `umbral_ae`=2; `enable`=1 from state 2.
- In IDLE, `fifo_empty` 8'hFF to 8'hFE -> next edge `estado`=3, `idle`=0; back to 8'hFF -> `estado`=2, `idle`=1.
- In ACTIVE, 1-cycle `fifo_error`=8'h20 -> `estado`=4, `enable`=0, `error_out`=8'h20; `init` pulses afterward -> stays 4 until `reset`, then all 0.
- Same edge `init`=1 and `fifo_error`=8'h01 in IDLE -> `estado`=4, `error_out`=8'h01.
- `reset` asserted mid-ACTIVE, asynchronously between edges -> outputs 0 immediately, `estado`=0.
- With `CTRL_THRESHOLD_CHECK_EN`: af_in=2, ae_in=3, `init`=0 -> `estado` stays 1; change ae_in=1 -> next edge `estado`=2. Without the macro -> `estado`=2 immediately.
